shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Command-queue front end that sits directly upstream of the shift/rotate unit.
- Accepts shift/rotate commands over a valid/ready interface and buffers them in a FIFO.
- Issues one command at a time to the shift/rotate unit by pulsing start, holds the command fields stable until finished, then captures the result.
- Presents results in order on a valid/ready output port for the downstream consumer.

Parameters:
- N, 8, data width and iteration-count width; matches the shift/rotate unit.
- DEPTH, 4, command FIFO depth; power of two, ≥2.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command FIFO not full.
- i_cmd_direction  in  1  1 = left, 0 = right.
- i_cmd_rotate  in  1  1 = rotate, 0 = shift.
- i_cmd_iterations  in  N  number of single-bit steps.
- i_cmd_value  in  N  operand.
- o_shift_start  out  1  one-cycle start pulse to the shift/rotate unit.
- o_shift_direction  out  1  held from the ISSUE cycle through WAIT.
- o_shift_rotate  out  1  held from the ISSUE cycle through WAIT.
- o_shift_iterations  out  N  held from the ISSUE cycle through WAIT.
- o_shift_value  out  N  operand, valid in the ISSUE cycle; held through WAIT.
- i_shift_finished  in  1  finished flag from the shift/rotate unit.
- i_shift_value  in  N  result from the shift/rotate unit.
- o_res_valid  out  1  result available.
- i_res_ready  in  1  consumer accepts result.
- o_res_value  out  N  captured result.
- o_busy  out  1  state ≠ IDLE or FIFO non-empty.

Behaviour:
- Reset: i_reset, synchronous, active-high, on clock i_clock. Reset values:
  - FIFO empty; state = IDLE.
  - o_cmd_ready = 1, o_shift_start = 0, o_res_valid = 0, o_busy = 0.
  - o_res_value = 0; o_shift_* fields = 0.
  - Reset mid-operation abandons the in-flight command and all queued commands; the shift/rotate unit shares the same reset.
- FIFO:
  - Push when i_cmd_valid & o_cmd_ready at the clock edge.
  - o_cmd_ready = ~full; there is no bypass when full.
  - Pop occurs on result capture (WAIT or ISSUE with i_shift_finished).
  - Simultaneous push and pop when not full: both take effect, count unchanged.
  - Read/write pointers are log2(DEPTH)+1 bits; full/empty are distinguished by the MSB.
- State machine:
  - IDLE: if the FIFO is non-empty, go to ISSUE; the head fields are registered into the o_shift_* registers.
  - ISSUE: o_shift_start = 1 for exactly this cycle.
    - If i_shift_finished is high in this cycle (iterations = 0): capture i_shift_value into o_res_value, pop, go to DONE.
    - Otherwise go to WAIT.
  - WAIT: o_shift_start = 0; o_shift_* fields held stable. On i_shift_finished: capture i_shift_value, pop, go to DONE.
  - DONE: o_res_valid = 1, o_res_value held.
    - On i_res_ready, go to IDLE; the next ISSUE is at least 2 cycles later.
    - The next command can never pulse start while the shift/rotate unit is still busy.
- i_shift_finished is ignored in IDLE and DONE; the shift/rotate unit's counter may wrap and re-assert it.
- Latency:
  - Command handshake in cycle c0.
  - IDLE in c1; ISSUE in c2.
  - i_shift_finished is expected in c2+k, where k = iterations.
  - o_res_valid rises in c0+k+3.
  - With k = 0, o_res_valid rises in c0+3.
- Backpressure: while DONE and i_res_ready = 0, o_res_value and o_res_valid are held and no new command is issued; the FIFO continues accepting pushes until full.
- Ordering: results are returned strictly in command order; no reordering or dropping.
- Width rules: iterations are unsigned N bits, passed unchanged; no clamping, so k ≥ N yields 0 for a shift and k mod N for a rotate, as computed by the shift/rotate unit.

Test Plan:
- Single command, rotate left, value 0x81, iterations 1 -> o_shift_start pulses exactly once in c2; o_res_value = 0x03, o_res_valid in c0+4.
- Shift right, value 0xF0, iterations 3 -> o_res_value = 0x1E in c0+6; direction, rotate and iterations stable through WAIT.
- Iterations 0, value 0xA5 -> finished in the ISSUE cycle; o_res_value = 0xA5, o_res_valid in c0+3.
- Hold i_res_ready = 0 and offer 6 back-to-back commands:
  - 5 are accepted (1 in DONE + 4 queued); o_cmd_ready = 0 on the 6th.
  - Release i_res_ready -> 5 results returned in order.
  - Then the 6th is accepted.
- Assert i_reset in WAIT of a 5-iteration rotate with 2 commands queued:
  - Next cycle: state IDLE, o_res_valid = 0, o_busy = 0, o_cmd_ready = 1.
  - No start pulse appears without a new push.
- Stimulus: hold i_shift_finished = 1 throughout DONE. Required response: no extra capture, no extra pop, and o_res_value unchanged.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Command, shift/rotate-unit and result channels of the shift sequencer.
// slave is the sequencer's view; master is the view of whatever surrounds it.
interface shift_sequencer_if #(
    parameter int unsigned N = 8
);
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic         i_cmd_direction;
    logic         i_cmd_rotate;
    logic [N-1:0] i_cmd_iterations;
    logic [N-1:0] i_cmd_value;

    logic         o_shift_start;
    logic         o_shift_direction;
    logic         o_shift_rotate;
    logic [N-1:0] o_shift_iterations;
    logic [N-1:0] o_shift_value;
    logic         i_shift_finished;
    logic [N-1:0] i_shift_value;

    logic         o_res_valid;
    logic         i_res_ready;
    logic [N-1:0] o_res_value;
    logic         o_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_direction, i_cmd_rotate, i_cmd_iterations, i_cmd_value,
        output o_cmd_ready,
        output o_shift_start, o_shift_direction, o_shift_rotate, o_shift_iterations, o_shift_value,
        input  i_shift_finished, i_shift_value,
        output o_res_valid, o_res_value, o_busy,
        input  i_res_ready
    );

    modport master (
        output i_cmd_valid, i_cmd_direction, i_cmd_rotate, i_cmd_iterations, i_cmd_value,
        input  o_cmd_ready,
        input  o_shift_start, o_shift_direction, o_shift_rotate, o_shift_iterations, o_shift_value,
        output i_shift_finished, i_shift_value,
        input  o_res_valid, o_res_value, o_busy,
        output i_res_ready
    );
endinterface

// File: rtl/shift_sequencer.sv
// Command FIFO in front of the shift/rotate unit: issues one command at a time,
// waits for finished, captures the result and hands it on in command order.
module shift_sequencer #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic              i_clock,
    input logic              i_reset,
    shift_sequencer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic         direction;
        logic         rotate;
        logic [N-1:0] iterations;
        logic [N-1:0] value;
    } cmd_t;

    state_t      state_q, state_d;
    cmd_t        fifo_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    cmd_t        issue_q, issue_d;
    logic [N-1:0] res_q, res_d;

    cmd_t cmd_in;
    logic full, empty, push, pop, load;

    assign cmd_in = '{direction:  bus.i_cmd_direction,
                      rotate:     bus.i_cmd_rotate,
                      iterations: bus.i_cmd_iterations,
                      value:      bus.i_cmd_value};

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.i_cmd_valid && !full;
    // The head stays queued until its result is captured, so pop == capture.
    assign pop   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && bus.i_shift_finished;
    assign load  = (state_q == S_IDLE) && !empty;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_ISSUE;
            S_ISSUE: state_d = bus.i_shift_finished ? S_DONE : S_WAIT;
            S_WAIT:  if (bus.i_shift_finished) state_d = S_DONE;
            S_DONE:  if (bus.i_res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_cmd_ready        = !full;
        bus.o_shift_start      = (state_q == S_ISSUE);
        bus.o_res_valid        = (state_q == S_DONE);
        bus.o_busy             = (state_q != S_IDLE) || !empty;
        bus.o_shift_direction  = issue_q.direction;
        bus.o_shift_rotate     = issue_q.rotate;
        bus.o_shift_iterations = issue_q.iterations;
        bus.o_shift_value      = issue_q.value;
        bus.o_res_value        = res_q;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        issue_d  = load ? fifo_q[rd_ptr_q[AW-1:0]] : issue_q;
        res_d    = pop  ? bus.i_shift_value : res_q;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            issue_q  <= '0;
            res_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            issue_q  <= issue_d;
            res_q    <= res_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= cmd_in;
        end
    end
endmodule
